// File: rtl/lfsr_seq_ctrl.sv
// Command sequencer for the display LFSR: loads seeds, issues counted or free-running
// shifts, and measures the cycle length of the attached LFSR by walking it back to its start.
module lfsr_seq_ctrl #(
  parameter int unsigned DIV      = 4,
  parameter int unsigned DIV_W    = 24,
  parameter int unsigned PERIOD_W = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [7:0]          cmd_arg,
  input  logic                stop,
  input  logic [7:0]          lfsr_q,
  output logic                lfsr_en,
  output logic                lfsr_load,
  output logic [7:0]          lfsr_seed,
  output logic                busy,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                timeout
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STEP,
    S_RUN,
    S_MEAS
  } state_t;

  typedef enum logic [1:0] {
    OP_STEP = 2'b00,
    OP_RUN  = 2'b01,
    OP_MEAS = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [PERIOD_W-1:0] MEAS_MAX = '1;

  state_t               state, state_nxt;
  op_t                  op;
  logic                 accept;
  logic [7:0]           step_rem;
  logic [DIV_W-1:0]     div_cnt;
  logic [PERIOD_W-1:0]  meas_cnt;
  logic [7:0]           meas_start;
  logic                 meas_hit;
  logic                 meas_expire;

  assign op        = op_t'(cmd_op);
  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // lfsr_en is decoded from the current lfsr_q and stop so that a MEASURE match or an abort
  // suppresses the shift in the very cycle it is seen; everything it depends on is registered.
  always_comb begin
    state_nxt   = state;
    lfsr_en     = 1'b0;
    meas_hit    = 1'b0;
    meas_expire = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_STEP: if (cmd_arg != '0) state_nxt = S_STEP;
            OP_RUN:  state_nxt = S_RUN;
            OP_MEAS: state_nxt = S_MEAS;
            default: state_nxt = S_LOAD;
          endcase
        end
      end
      S_LOAD: state_nxt = S_IDLE;
      S_STEP: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else begin
          lfsr_en = 1'b1;
          if (step_rem == 8'd1) state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) state_nxt = S_IDLE;
        else      lfsr_en   = (div_cnt == DIV_LAST);
      end
      S_MEAS: begin
        if (stop) begin
          state_nxt = S_IDLE;
        end else if ((meas_cnt != '0) && (lfsr_q == meas_start)) begin
          meas_hit  = 1'b1;
          state_nxt = S_IDLE;
        end else if (meas_cnt == MEAS_MAX) begin
          meas_expire = 1'b1;
          state_nxt   = S_IDLE;
        end else begin
          lfsr_en = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_load    <= 1'b0;
      lfsr_seed    <= '0;
      step_rem     <= '0;
      div_cnt      <= '0;
      meas_cnt     <= '0;
      meas_start   <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      lfsr_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            case (op)
              OP_STEP: step_rem <= cmd_arg;
              OP_RUN:  div_cnt  <= '0;
              OP_MEAS: begin
                meas_start   <= lfsr_q;
                meas_cnt     <= '0;
                period       <= '0;
                period_valid <= 1'b0;
                timeout      <= 1'b0;
              end
              default: begin
                lfsr_load <= 1'b1;
                lfsr_seed <= (cmd_arg == '0) ? 8'h01 : cmd_arg;
              end
            endcase
          end
        end
        S_STEP: begin
          if (!stop) step_rem <= step_rem - 8'd1;
        end
        S_RUN: begin
          div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        end
        S_MEAS: begin
          if (lfsr_en) meas_cnt <= meas_cnt + PERIOD_W'(1);
          if (meas_hit) begin
            period       <= meas_cnt;
            period_valid <= 1'b1;
          end
          if (meas_expire) begin
            period       <= '0;
            period_valid <= 1'b1;
            timeout      <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: drives commands against a behavioural LFSR and checks
// load/step/run pulse timing, period measurement, timeout, abort and reset behaviour.
module tb_lfsr_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       stop;
  logic [7:0] lfsr_q;
  logic       lfsr_en;
  logic       lfsr_load;
  logic [7:0] lfsr_seed;
  logic       busy;
  logic [8:0] period;
  logic       period_valid;
  logic       timeout;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned overlap  = 0;

  // 0: x^8+x^6+x^5+x^4+1 shift register, 1: frozen, 2: collapses to 8'h00 on any shift
  int unsigned mode = 0;
  logic [7:0]  mq   = 8'h00;

  assign lfsr_q = mq;

  lfsr_seq_ctrl #(.DIV(4), .DIV_W(24), .PERIOD_W(9)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .stop         (stop),
    .lfsr_q       (lfsr_q),
    .lfsr_en      (lfsr_en),
    .lfsr_load    (lfsr_load),
    .lfsr_seed    (lfsr_seed),
    .busy         (busy),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (lfsr_load) mq <= lfsr_seed;
    else if (lfsr_en) begin
      case (mode)
        0:       mq <= {mq[6:0], mq[7] ^ mq[5] ^ mq[4] ^ mq[3]};
        1:       mq <= mq;
        default: mq <= 8'h00;
      endcase
    end
  end

  always @(negedge clk) if (lfsr_en && lfsr_load) overlap++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Present one command for a single cycle; returns in the cycle after accept.
  task automatic issue(input logic [1:0] op, input logic [7:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    next_cyc();
    cmd_valid = 1'b0;
    #1;
  endtask

  task automatic wait_idle(input int unsigned limit, output int unsigned shifts);
    shifts = 0;
    for (int i = 0; i < limit && busy; i++) begin
      if (lfsr_en) shifts++;
      next_cyc();
    end
  endtask

  int unsigned n;
  logic [7:0]  held;

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 8'h00; stop = 1'b0;
    #2;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(lfsr_en), 32'd0);
    check("rst_load", 32'(lfsr_load), 32'd0);
    check("rst_seed", 32'(lfsr_seed), 32'h00);
    check("rst_period", 32'(period), 32'd0);
    check("rst_pv", 32'(period_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    next_cyc(); next_cyc();
    rst = 1'b1;
    next_cyc();

    // LOAD: zero seed is replaced, non-zero passes through, one busy cycle each
    issue(2'b11, 8'h00);
    check("load0_load", 32'(lfsr_load), 32'd1);
    check("load0_seed", 32'(lfsr_seed), 32'h01);
    check("load0_busy", 32'(busy), 32'd1);
    check("load0_en", 32'(lfsr_en), 32'd0);
    next_cyc();
    check("load0_done_load", 32'(lfsr_load), 32'd0);
    check("load0_done_busy", 32'(busy), 32'd0);
    issue(2'b11, 8'hA5);
    check("loadA5_seed", 32'(lfsr_seed), 32'hA5);
    check("loadA5_busy", 32'(busy), 32'd1);
    next_cyc();
    check("loadA5_q", 32'(lfsr_q), 32'hA5);

    // STEP 5: five consecutive shifts from accept+1, A5 walks to A9
    issue(2'b00, 8'd5);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("step5_en_%0d", i), 32'(lfsr_en), (i <= 5) ? 32'd1 : 32'd0);
      check($sformatf("step5_ready_%0d", i), 32'(cmd_ready), (i <= 5) ? 32'd0 : 32'd1);
      next_cyc();
    end
    check("step5_q", 32'(lfsr_q), 32'hA9);
    issue(2'b00, 8'd0);
    check("step0_busy", 32'(busy), 32'd0);
    check("step0_en", 32'(lfsr_en), 32'd0);
    check("step0_q", 32'(lfsr_q), 32'hA9);

    // RUN with DIV=4: pulses at accept+4, +8, +12
    issue(2'b01, 8'h00);
    for (int i = 1; i <= 13; i++) begin
      check($sformatf("run_en_%0d", i), 32'(lfsr_en), (i % 4 == 0) ? 32'd1 : 32'd0);
      next_cyc();
    end
    stop = 1'b1; #1;
    check("run_stop_en", 32'(lfsr_en), 32'd0);
    next_cyc();
    stop = 1'b0; #1;
    check("run_stop_idle", 32'(busy), 32'd0);

    // RUN stopped at accept+10: no pulse after +8, IDLE at +11
    issue(2'b01, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      check($sformatf("run2_en_%0d", i), 32'(lfsr_en), (i % 4 == 0) ? 32'd1 : 32'd0);
      next_cyc();
    end
    stop = 1'b1; #1;
    check("run2_stop10_en", 32'(lfsr_en), 32'd0);
    check("run2_stop10_busy", 32'(busy), 32'd1);
    next_cyc();
    check("run2_idle11", 32'(cmd_ready), 32'd1);
    check("run2_idle11_en", 32'(lfsr_en), 32'd0);

    // stop is still high here: an IDLE accept must not be blocked by it
    issue(2'b11, 8'h01);
    stop = 1'b0; #1;
    check("idle_stop_load", 32'(lfsr_load), 32'd1);
    next_cyc();
    check("idle_stop_q", 32'(lfsr_q), 32'h01);

    // MEASURE of a maximal-length LFSR from 8'h01
    mode = 0;
    issue(2'b10, 8'h00);
    check("meas_busy", 32'(busy), 32'd1);
    wait_idle(600, n);
    check("meas_idle", 32'(busy), 32'd0);
    check("meas_period", 32'(period), 32'd255);
    check("meas_pv", 32'(period_valid), 32'd1);
    check("meas_timeout", 32'(timeout), 32'd0);
    check("meas_shifts", n, 32'd255);
    check("meas_end_q", 32'(lfsr_q), 32'h01);

    // MEASURE of a frozen LFSR
    mode = 1;
    issue(2'b10, 8'h00);
    check("const_pv_cleared", 32'(period_valid), 32'd0);
    wait_idle(20, n);
    check("const_period", 32'(period), 32'd1);
    check("const_pv", 32'(period_valid), 32'd1);
    check("const_shifts", n, 32'd1);

    // MEASURE that never returns to its start: 511 shifts, then timeout
    mode = 2;
    issue(2'b10, 8'h00);
    wait_idle(1200, n);
    check("to_idle", 32'(busy), 32'd0);
    check("to_shifts", n, 32'd511);
    check("to_period", 32'(period), 32'd0);
    check("to_timeout", 32'(timeout), 32'd1);
    check("to_pv", 32'(period_valid), 32'd1);

    // aborted MEASURE leaves no result
    mode = 0;
    issue(2'b11, 8'h01);
    next_cyc();
    issue(2'b10, 8'h00);
    for (int i = 0; i < 20; i++) next_cyc();
    stop = 1'b1; #1;
    check("abort_en", 32'(lfsr_en), 32'd0);
    next_cyc();
    stop = 1'b0; #1;
    check("abort_idle", 32'(busy), 32'd0);
    check("abort_pv", 32'(period_valid), 32'd0);
    check("abort_timeout", 32'(timeout), 32'd0);

    // reset during RUN after a valid measurement
    mode = 1;
    issue(2'b10, 8'h00);
    wait_idle(20, n);
    check("pre_rst_period", 32'(period), 32'd1);
    issue(2'b01, 8'h00);
    next_cyc(); next_cyc();
    check("pre_rst_en", 32'(lfsr_en), 32'd0);
    next_cyc();
    check("rst_run_en_hi", 32'(lfsr_en), 32'd1);
    held = lfsr_q;
    rst = 1'b0; #1;
    check("rst_run_en", 32'(lfsr_en), 32'd0);
    check("rst_run_busy", 32'(busy), 32'd0);
    check("rst_run_ready", 32'(cmd_ready), 32'd1);
    check("rst_run_period", 32'(period), 32'd0);
    check("rst_run_pv", 32'(period_valid), 32'd0);
    mode = 0;
    next_cyc();
    check("rst_run_noshift", 32'(lfsr_q), 32'(held));
    check("rst_run_period_hold", 32'(period), 32'd0);
    rst = 1'b1;
    next_cyc();
    check("rst_rel_busy", 32'(busy), 32'd0);
    check("rst_rel_en", 32'(lfsr_en), 32'd0);

    check("en_load_exclusive", overlap, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
